pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime.sv | 117 +++++++++++
 tb/tb_pwm_deadtime.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary gate driver: turns a raw PWM into non-overlapping high/low
// drives with a programmable dead time, enable gating and a sticky fault latch.
module pwm_deadtime #(
  parameter int W = 5
) (
  input  logic         clk50m,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm,
  input  logic [W-1:0] dt,
  input  logic         flt,
  input  logic         clr,
  output logic         hi,
  output logic         lo,
  output logic         dead,
  output logic         fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_ON  = 3'd1,
    DEAD_H = 3'd2,
    HI_ON  = 3'd3,
    DEAD_L = 3'd4,
    FAULT  = 3'd5
  } state_e;

  state_e       state_q, state_d;
  logic         p_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload;
  logic         hi_q, lo_q, dead_q, fault_q;

  // D-1 with D = max(dt,1); a setting of 0 behaves like 1.
  assign reload = (dt == '0) ? '0 : dt - W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flt) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      if (clr) state_d = IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = p_q ? DEAD_H : DEAD_L;
          cnt_d   = reload;
        end
        LO_ON: begin
          if (p_q) begin
            state_d = DEAD_H;
            cnt_d   = reload;
          end
        end
        HI_ON: begin
          if (!p_q) begin
            state_d = DEAD_L;
            cnt_d   = reload;
          end
        end
        DEAD_H: begin
          // A revert restarts the full dead interval toward the other side.
          if (!p_q) begin
            state_d = DEAD_L;
            cnt_d   = reload;
          end else if (cnt_q == '0) begin
            state_d = HI_ON;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        DEAD_L: begin
          if (p_q) begin
            state_d = DEAD_H;
            cnt_d   = reload;
          end else if (cnt_q == '0) begin
            state_d = LO_ON;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state they belong to.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dead_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= pwm;
      cnt_q   <= cnt_d;
      hi_q    <= (state_d == HI_ON);
      lo_q    <= (state_d == LO_ON);
      dead_q  <= (state_d == DEAD_H) || (state_d == DEAD_L);
      fault_q <= (state_d == FAULT);
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign dead  = dead_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and randomised checks for pwm_deadtime; output vectors are
// ordered {hi, lo, dead, fault}.
module tb_pwm_deadtime;
  localparam int W = 5;

  logic         clk50m = 1'b0;
  logic         rst_n, en, pwm, flt, clr;
  logic [W-1:0] dt;
  logic         hi, lo, dead, fault;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk50m = ~clk50m;

  pwm_deadtime #(.W(W)) dut (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .en     (en),
    .pwm    (pwm),
    .dt     (dt),
    .flt    (flt),
    .clr    (clr),
    .hi     (hi),
    .lo     (lo),
    .dead   (dead),
    .fault  (fault)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk50m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pwm = 1'b0; flt = 1'b0; clr = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pwm = 1'b1; flt = 1'b1; clr = 1'b0; dt = 5'd3;
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_values: got %b required 0000", {hi, lo, dead, fault});
    end
    rst_n = 1'b1; en = 1'b0; flt = 1'b0; pwm = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_en_low: got %b required 0000", {hi, lo, dead, fault});
    end
    flt = 1'b1;
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0001) begin
      n_err++;
      $display("FAIL flt_over_en: got %b required 0001", {hi, lo, dead, fault});
    end
    flt = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_clears_fault: got %b required 0000", {hi, lo, dead, fault});
    end
  endtask

  task automatic test_basic_deadtime();
    logic [3:0] exp_v [6];
    exp_v = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
    do_reset();
    dt = 5'd3; en = 1'b1; pwm = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0100) begin
      n_err++;
      $display("FAIL basic_lo_on: got %b required 0100", {hi, lo, dead, fault});
    end
    pwm = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({hi, lo, dead, fault} !== exp_v[k]) begin
        n_err++;
        $display("FAIL basic_edge cycle %0d: got %b required %b", k + 1,
                 {hi, lo, dead, fault}, exp_v[k]);
      end
    end
  endtask

  task automatic test_dt_latch();
    logic [3:0] exp_v [6];
    exp_v = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
    do_reset();
    dt = 5'd3; en = 1'b1; pwm = 1'b0;
    repeat (10) tick();
    pwm = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 1) dt = 5'd20;
      n_cmp++;
      if ({hi, lo, dead, fault} !== exp_v[k]) begin
        n_err++;
        $display("FAIL dt_latch cycle %0d: got %b required %b", k + 1,
                 {hi, lo, dead, fault}, exp_v[k]);
      end
    end
  endtask

  task automatic test_dt_zero();
    logic [3:0] on_new, on_old;
    do_reset();
    dt = 5'd0; en = 1'b1; pwm = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0100) begin
      n_err++;
      $display("FAIL dt0_lo_on: got %b required 0100", {hi, lo, dead, fault});
    end
    for (int t = 0; t < 6; t++) begin
      pwm    = ~pwm;
      on_new = pwm ? 4'b1000 : 4'b0100;
      on_old = pwm ? 4'b0100 : 4'b1000;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k == 1 || k == 3 || k == 8) begin
          n_cmp++;
          if ({hi, lo, dead, fault} !== ((k == 1) ? on_old : on_new)) begin
            n_err++;
            $display("FAIL dt0_toggle %0d cycle %0d: got %b required %b", t, k,
                     {hi, lo, dead, fault}, (k == 1) ? on_old : on_new);
          end
        end else if (k == 2) begin
          n_cmp++;
          if ({hi, lo, dead, fault} !== 4'b0010) begin
            n_err++;
            $display("FAIL dt0_dead %0d: got %b required 0010", t, {hi, lo, dead, fault});
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_v [9];
    exp_v = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
              4'b0010, 4'b0010, 4'b0100, 4'b0100};
    do_reset();
    dt = 5'd4; en = 1'b1; pwm = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0100) begin
      n_err++;
      $display("FAIL glitch_lo_on: got %b required 0100", {hi, lo, dead, fault});
    end
    pwm = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 1) pwm = 1'b0;
      n_cmp++;
      if ({hi, lo, dead, fault} !== exp_v[k]) begin
        n_err++;
        $display("FAIL glitch cycle %0d: got %b required %b", k + 1,
                 {hi, lo, dead, fault}, exp_v[k]);
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] exp_v [4];
    exp_v = '{4'b0000, 4'b0010, 4'b0010, 4'b1000};
    do_reset();
    dt = 5'd2; en = 1'b1; pwm = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b1000) begin
      n_err++;
      $display("FAIL fault_hi_on: got %b required 1000", {hi, lo, dead, fault});
    end
    flt = 1'b1;
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0001) begin
      n_err++;
      $display("FAIL fault_entry: got %b required 0001", {hi, lo, dead, fault});
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0001) begin
      n_err++;
      $display("FAIL fault_clr_ignored: got %b required 0001", {hi, lo, dead, fault});
    end
    flt = 1'b0; en = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0001) begin
      n_err++;
      $display("FAIL fault_sticky: got %b required 0001", {hi, lo, dead, fault});
    end
    en = 1'b1; clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      clr = 1'b0;
      n_cmp++;
      if ({hi, lo, dead, fault} !== exp_v[k]) begin
        n_err++;
        $display("FAIL fault_recover cycle %0d: got %b required %b", k,
                 {hi, lo, dead, fault}, exp_v[k]);
      end
    end
  endtask

  task automatic test_enable_reset();
    do_reset();
    dt = 5'd1; en = 1'b1; pwm = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b1000) begin
      n_err++;
      $display("FAIL en_hi_on: got %b required 1000", {hi, lo, dead, fault});
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0000) begin
      n_err++;
      $display("FAIL en_off: got %b required 0000", {hi, lo, dead, fault});
    end
    dt = 5'd31; en = 1'b1;
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0010) begin
      n_err++;
      $display("FAIL en_dead_h: got %b required 0010", {hi, lo, dead, fault});
    end
    repeat (5) tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0010) begin
      n_err++;
      $display("FAIL dt31_hold: got %b required 0010", {hi, lo, dead, fault});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_in_dead: got %b required 0000", {hi, lo, dead, fault});
    end
    tick();
    n_cmp++;
    if ({hi, lo, dead, fault} !== 4'b0010) begin
      n_err++;
      $display("FAIL post_reset_dead: got %b required 0010", {hi, lo, dead, fault});
    end
  endtask

  task automatic test_random();
    int   low_run, min_d, d_at, rises;
    logic prev_hi, prev_lo;
    do_reset();
    dt = 5'd2; en = 1'b1; pwm = 1'b0;
    low_run = 0; min_d = 99; rises = 0; prev_hi = 1'b0; prev_lo = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      d_at = (dt == '0) ? 1 : int'(dt);
      tick();
      n_cmp++;
      if (hi && lo) begin
        n_err++;
        $display("FAIL rand_overlap cycle %0d: got hi=%b lo=%b required not both", c, hi, lo);
      end
      if ((hi && !prev_hi) || (lo && !prev_lo)) begin
        n_cmp++;
        if (low_run < min_d) begin
          n_err++;
          $display("FAIL rand_deadtime cycle %0d: got %0d both-low cycles required >= %0d",
                   c, low_run, min_d);
        end
        rises++;
        low_run = 0; min_d = 99;
      end else if (!hi && !lo) begin
        low_run++;
        if (d_at < min_d) min_d = d_at;
      end else begin
        low_run = 0; min_d = 99;
      end
      prev_hi = hi; prev_lo = lo;
      if ($urandom_range(0, 5) == 0)  pwm = ~pwm;
      if ($urandom_range(0, 39) == 0) dt = W'($urandom_range(0, 9));
      en    = ($urandom_range(0, 99) != 0);
      flt   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    n_cmp++;
    if (rises < 20) begin
      n_err++;
      $display("FAIL rand_activity: got %0d output rises required >= 20", rises);
    end
    rst_n = 1'b1; flt = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_deadtime();
    test_dt_latch();
    test_dt_zero();
    test_glitch();
    test_fault();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
